// File: rtl/data_bus_arb_pkg.sv
// Shared types for the two-master data-bus arbiter: FSM states, master index
// and the round-robin priority rotation helper.
package data_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mst_e;

    // The master just served drops to lowest priority.
    function automatic mst_e next_prio(input mst_e owner);
        mst_e result;
        case (owner)
            M0:      result = M1;
            M1:      result = M0;
            default: result = M0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_bus_arb_timeout.sv
// Response watchdog for the arbiter: cleared when a grant enters WAIT, counts
// WAIT cycles without a response, flags expiry at TIMEOUT_CYCLES.
module data_bus_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter; holds at the limit so expiry cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (start) begin
            count_r <= {CNT_W{1'b0}};
        end else if (run && (count_r != LIMIT)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = run && (count_r == LIMIT);

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid slave port between m0 and m1,
// one outstanding transaction. Optional watchdog: DATA_BUS_ARBITER_TIMEOUT_EN.
module data_bus_arbiter
    import data_bus_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_req,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_we,
    output logic [DATA_W/8-1:0] s_be,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic                s_gnt,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_err
);

    localparam int BE_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("data_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_r;
    mst_e              prio_r;
    mst_e              owner_r;
    mst_e              sel_r;
    mst_e              sel_s;
    logic              fwd_s;
    logic              resp_s;
    logic              timeout_s;
    logic [DATA_W-1:0] rsp_data_s;
    logic              rsp_err_s;

`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
    logic start_s;
    logic run_s;

    assign start_s = fwd_s && s_gnt;
    assign run_s   = !rst && (state_r == WAIT) && !s_rvalid;

    data_bus_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .run    (run_s),
        .expire (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Pick the master to forward: fresh choice in IDLE, the latched one in HOLD.
    always_comb begin
        sel_s = sel_r;
        fwd_s = 1'b0;
        if (rst) begin
            sel_s = sel_r;
            fwd_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    fwd_s = m0_req || m1_req;
                    if (m0_req && m1_req) begin
                        sel_s = prio_r;
                    end else if (m1_req) begin
                        sel_s = M1;
                    end else begin
                        sel_s = M0;
                    end
                end
                HOLD: begin
                    fwd_s = 1'b1;
                    sel_s = sel_r;
                end
                default: begin
                    fwd_s = 1'b0;
                    sel_s = sel_r;
                end
            endcase
        end
    end

    // Request forwarding and grant steering; idle bus fields are driven to zero.
    always_comb begin
        s_req   = fwd_s;
        s_addr  = {ADDR_W{1'b0}};
        s_we    = 1'b0;
        s_be    = {BE_W{1'b0}};
        s_wdata = {DATA_W{1'b0}};
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        if (fwd_s && (sel_s == M1)) begin
            s_addr  = m1_addr;
            s_we    = m1_we;
            s_be    = m1_be;
            s_wdata = m1_wdata;
            m1_gnt  = s_gnt;
        end else if (fwd_s) begin
            s_addr  = m0_addr;
            s_we    = m0_we;
            s_be    = m0_be;
            s_wdata = m0_wdata;
            m0_gnt  = s_gnt;
        end else begin
            s_addr  = {ADDR_W{1'b0}};
        end
    end

    // Response routing; a watchdog expiry looks like an error with zero data.
    always_comb begin
        resp_s     = !rst && (state_r == WAIT) && (s_rvalid || timeout_s);
        rsp_data_s = s_rvalid ? s_rdata : {DATA_W{1'b0}};
        rsp_err_s  = s_rvalid ? s_err : 1'b1;
        m0_rvalid  = 1'b0;
        m0_rdata   = {DATA_W{1'b0}};
        m0_err     = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = {DATA_W{1'b0}};
        m1_err     = 1'b0;
        if (resp_s && (owner_r == M1)) begin
            m1_rvalid = 1'b1;
            m1_rdata  = rsp_data_s;
            m1_err    = rsp_err_s;
        end else if (resp_s) begin
            m0_rvalid = 1'b1;
            m0_rdata  = rsp_data_s;
            m0_err    = rsp_err_s;
        end else begin
            m0_rvalid = 1'b0;
        end
    end

    // Arbitration FSM with round-robin priority and owner tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= M0;
            owner_r <= M0;
            sel_r   <= M0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fwd_s && s_gnt) begin
                        owner_r <= sel_s;
                        state_r <= WAIT;
                    end else if (fwd_s) begin
                        sel_r   <= sel_s;
                        state_r <= HOLD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD: begin
                    if (s_gnt) begin
                        owner_r <= sel_r;
                        state_r <= WAIT;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                WAIT: begin
                    if (s_rvalid || timeout_s) begin
                        prio_r  <= next_prio(owner_r);
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed self-checking bench for data_bus_arbiter; the timeout scenario runs
// only when DATA_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    task automatic clear_inputs();
        m0_req = 1'b0; m0_addr = 32'h0; m0_we = 1'b0; m0_be = 4'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_addr = 32'h0; m1_we = 1'b0; m1_be = 4'h0; m1_wdata = 32'h0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_err = 1'b0;
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        total++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}); end
        total++; if ({s_addr, s_wdata, s_be, m0_rdata, m1_rdata} !== 132'h0) begin bad++; $display("FAIL reset_buses got=%h exp=0", {s_addr, s_wdata, s_be, m0_rdata, m1_rdata}); end
    endtask

    task automatic test_single_read();
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h0001_0004; m0_be = 4'hF; s_gnt = 1'b1;
        #2;
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL sr_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
        total++; if (s_req !== 1'b1 || s_addr !== 32'h0001_0004) begin bad++; $display("FAIL sr_fwd got=%b/%h exp=1/00010004", s_req, s_addr); end
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0;
        #2;
        total++; if (s_req !== 1'b0 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL sr_wait got=%b%b exp=00", s_req, m0_rvalid); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #2;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sr_rdata got=%b/%h exp=1/deadbeef", m0_rvalid, m0_rdata); end
        total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m1_gnt !== 1'b0) begin bad++; $display("FAIL sr_m1_quiet got=%b/%h/%b exp=0/0/0", m1_rvalid, m1_rdata, m1_gnt); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [1:0] exp_owner;
        do_reset();
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        for (int r = 0; r < 4; r++) begin
            exp_owner = (r % 2 == 0) ? 2'b01 : 2'b10;
            m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b0;
            #2;
            total++; if ({m1_gnt, m0_gnt} !== exp_owner) begin bad++; $display("FAIL rr_grant round=%0d got=%b exp=%b", r, {m1_gnt, m0_gnt}, exp_owner); end
            total++; if (s_addr !== ((r % 2 == 0) ? 32'h100 : 32'h200)) begin bad++; $display("FAIL rr_addr round=%0d got=%h", r, s_addr); end
            next_cycle();
            if (r % 2 == 0) m0_req = 1'b0; else m1_req = 1'b0;
            s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_00A0 + 32'(r);
            #2;
            total++; if ({m1_rvalid, m0_rvalid} !== exp_owner) begin bad++; $display("FAIL rr_rvalid round=%0d got=%b exp=%b", r, {m1_rvalid, m0_rvalid}, exp_owner); end
            total++; if ({m1_gnt, m0_gnt, s_req} !== 3'b000) begin bad++; $display("FAIL rr_no_gnt_on_rvalid round=%0d got=%b exp=000", r, {m1_gnt, m0_gnt, s_req}); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_grant_stall();
        next_cycle();
        m1_req = 1'b1; m1_addr = 32'hA000_0000; s_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin m0_req = 1'b1; m0_addr = 32'hB000_0000; end
            if (c == 3) s_gnt = 1'b1;
            #2;
            total++; if (s_addr !== 32'hA000_0000 || s_req !== 1'b1) begin bad++; $display("FAIL stall_addr cyc=%0d got=%h/%b exp=a0000000/1", c, s_addr, s_req); end
            total++; if ({m1_gnt, m0_gnt} !== ((c == 3) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL stall_gnt cyc=%0d got=%b", c, {m1_gnt, m0_gnt}); end
            next_cycle();
        end
        m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
        #2;
        total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1111_2222 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL stall_rsp got=%b/%h/%b exp=1/11112222/0", m1_rvalid, m1_rdata, m0_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; s_gnt = 1'b1;
        #2;
        total++; if (m0_gnt !== 1'b1 || s_addr !== 32'hB000_0000) begin bad++; $display("FAIL stall_m0_next got=%b/%h exp=1/b0000000", m0_gnt, s_addr); end
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3333_4444;
        #2;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h3333_4444) begin bad++; $display("FAIL stall_m0_rsp got=%b/%h exp=1/33334444", m0_rvalid, m0_rdata); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_write_err();
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'h1234_5678; m1_addr = 32'h0000_0040;
        m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'hFFFF_FFFF;
        s_gnt = 1'b1;
        #2;
        total++; if (s_we !== 1'b1 || s_be !== 4'b0011 || s_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_fwd got=%b/%b/%h exp=1/0011/12345678", s_we, s_be, s_wdata); end
        total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b exp=1", m1_gnt); end
        next_cycle();
        m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b1;
        #2;
        total++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b/%b/%b exp=1/1/0", m1_rvalid, m1_err, m0_err); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h0000_0800; s_gnt = 1'b1;
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0; rst = 1'b1;
        #2;
        total++; if (m0_rvalid !== 1'b0 || s_req !== 1'b0) begin bad++; $display("FAIL rstw_during got=%b/%b exp=0/0", m0_rvalid, s_req); end
        next_cycle();
        rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_err = 1'b1;
        #2;
        total++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000 || m0_rdata !== 32'h0) begin bad++; $display("FAIL rstw_dropped got=%b/%h exp=0000/0", {m0_rvalid, m1_rvalid, m0_err, m1_err}, m0_rdata); end
        next_cycle();
        s_rvalid = 1'b0; s_err = 1'b0; m0_req = 1'b1; s_gnt = 1'b1;
        #2;
        total++; if (m0_gnt !== 1'b1 || s_addr !== 32'h0000_0800) begin bad++; $display("FAIL rstw_regrant got=%b/%h exp=1/00000800", m0_gnt, s_addr); end
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
        #2;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL rstw_rsp got=%b/%h exp=1/5555aaaa", m0_rvalid, m0_rdata); end
        next_cycle();
        clear_inputs();
    endtask

`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        next_cycle();
        m0_req = 1'b1; s_gnt = 1'b1;
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%b exp=0", c, m0_rvalid); end
            next_cycle();
        end
        #2;
        total++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin bad++; $display("FAIL to_expire got=%b/%b/%h exp=1/1/0", m0_rvalid, m0_err, m0_rdata); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h7777_7777;
        #2;
        total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin bad++; $display("FAIL to_late_ignored got=%b%b exp=00", m0_rvalid, m1_rvalid); end
        next_cycle();
        clear_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_grant_stall();
        test_write_err();
        test_reset_mid_wait();
`ifdef DATA_BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
